// File: rtl/mem_port_arbiter_if.sv
// One requester's port onto the shared RAM: request/grant handshake, write
// payload and the read-return channel.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wmask;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (output req, addr, wmask, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, wmask, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 32-bit block RAM between two requesters, round-robin
// with a bounded burst so neither port can starve the other.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_port_arbiter_if.slave m0,
    mem_port_arbiter_if.slave m1,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rstrb_o,
    output logic [3:0]        mem_wmask_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);
    localparam int NREQ  = 2;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_e;

    owner_e                      owner_q, owner_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NREQ-1:0]             req, gnt, is_rd, rvalid_q, rvalid_d;
    logic [NREQ-1:0][ADDR_W-1:0] addr;
    logic [NREQ-1:0][3:0]        wmask;
    logic [NREQ-1:0][31:0]       wdata;
    logic                        burst_open;

    assign req   = {m1.req, m0.req};
    assign addr  = {m1.addr, m0.addr};
    assign wmask = {m1.wmask, m0.wmask};
    assign wdata = {m1.wdata, m0.wdata};

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    assign m0.rvalid = rvalid_q[0];
    assign m1.rvalid = rvalid_q[1];
    assign m0.rdata  = mem_rdata_i;
    assign m1.rdata  = mem_rdata_i;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign is_rd[i]    = (wmask[i] == 4'b0000);
        assign rvalid_d[i] = gnt[i] & is_rd[i];
    end

    assign burst_open = (int'(cnt_q) < BURST_LEN);

    // Grants are gated by reset so the RAM sees an idle bus while rst_ni is low.
    always_comb begin
        gnt = '0;
        if (rst_ni) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    if (burst_open) gnt = (owner_q == OWN_M1) ? 2'b10 : 2'b01;
                    else            gnt = (owner_q == OWN_M1) ? 2'b01 : 2'b10;
                end
                default: gnt = '0;
            endcase
        end
    end

    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (gnt == '0) begin
            cnt_d = '0;
        end else if (gnt[1] == (owner_q == OWN_M1)) begin
            if (burst_open) cnt_d = cnt_q + 1'b1;
        end else begin
            owner_d = gnt[1] ? OWN_M1 : OWN_M0;
            cnt_d   = CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= OWN_M0;
            cnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_wmask_o = '0;
        mem_wdata_o = '0;
        mem_rstrb_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mem_addr_o  = addr[i];
                mem_wmask_o = wmask[i];
                mem_wdata_o = wdata[i];
                mem_rstrb_o = is_rd[i];
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/read returns, a monitor
// pops and compares whenever either DUT (BURST_LEN 4 and 1) presents them.
module tb_mem_port_arbiter;
    typedef struct {
        int          cyc;
        int          who;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        rstrb;
    } gexp_t;
    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;
    gexp_t gq[2][$];
    rexp_t rq[2][2][$];
    event  mid_ev;
    logic  mid_rv = 1'b0;
    logic  mid_zero = 1'b0;
    logic  done = 1'b0;

    // stimulus drive [dut][port]
    logic        r[2][2];
    logic [31:0] a[2][2];
    logic [3:0]  wm[2][2];
    logic [31:0] wd[2][2];

    // observed [dut][port]
    logic        gv[2][2];
    logic        rv[2][2];
    logic [31:0] rd[2][2];
    logic [31:0] maddr[2], mwd[2], mrd[2];
    logic [3:0]  mwm[2];
    logic        mrs[2];

    mem_port_arbiter_if #(.ADDR_W(32)) ia0 ();
    mem_port_arbiter_if #(.ADDR_W(32)) ia1 ();
    mem_port_arbiter_if #(.ADDR_W(32)) ib0 ();
    mem_port_arbiter_if #(.ADDR_W(32)) ib1 ();

    mem_port_arbiter #(.ADDR_W(32), .BURST_LEN(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .m0(ia0), .m1(ia1),
        .mem_addr_o(maddr[0]), .mem_rstrb_o(mrs[0]), .mem_wmask_o(mwm[0]),
        .mem_wdata_o(mwd[0]), .mem_rdata_i(mrd[0])
    );
    mem_port_arbiter #(.ADDR_W(32), .BURST_LEN(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .m0(ib0), .m1(ib1),
        .mem_addr_o(maddr[1]), .mem_rstrb_o(mrs[1]), .mem_wmask_o(mwm[1]),
        .mem_wdata_o(mwd[1]), .mem_rdata_i(mrd[1])
    );

    assign ia0.req = r[0][0]; assign ia0.addr = a[0][0]; assign ia0.wmask = wm[0][0]; assign ia0.wdata = wd[0][0];
    assign ia1.req = r[0][1]; assign ia1.addr = a[0][1]; assign ia1.wmask = wm[0][1]; assign ia1.wdata = wd[0][1];
    assign ib0.req = r[1][0]; assign ib0.addr = a[1][0]; assign ib0.wmask = wm[1][0]; assign ib0.wdata = wd[1][0];
    assign ib1.req = r[1][1]; assign ib1.addr = a[1][1]; assign ib1.wmask = wm[1][1]; assign ib1.wdata = wd[1][1];

    assign gv[0][0] = ia0.gnt; assign rv[0][0] = ia0.rvalid; assign rd[0][0] = ia0.rdata;
    assign gv[0][1] = ia1.gnt; assign rv[0][1] = ia1.rvalid; assign rd[0][1] = ia1.rdata;
    assign gv[1][0] = ib0.gnt; assign rv[1][0] = ib0.rvalid; assign rd[1][0] = ib0.rdata;
    assign gv[1][1] = ib1.gnt; assign rv[1][1] = ib1.rvalid; assign rd[1][1] = ib1.rdata;

    function automatic logic [31:0] ramval(input logic [31:0] ad);
        return (ad == 32'h10) ? 32'hDEADBEEF : {ad[15:0], ~ad[15:0]};
    endfunction

    // RAM model: read data valid the cycle after the read strobe
    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            if (mrs[d]) mrd[d] <= ramval(maddr[d]);

    task automatic drv(input int d, input int p, input logic q, input logic [31:0] ad,
                       input logic [3:0] m, input logic [31:0] w);
        r[d][p] = q; a[d][p] = ad; wm[d][p] = m; wd[d][p] = w;
    endtask

    task automatic exp(input int d, input int g);
        gexp_t e;
        rexp_t x;
        e.cyc = cyc; e.who = g; e.addr = a[d][g]; e.wmask = wm[d][g];
        e.wdata = wd[d][g]; e.rstrb = (wm[d][g] == 4'h0);
        gq[d].push_back(e);
        if (wm[d][g] == 4'h0) begin
            x.cyc = cyc + 1; x.data = ramval(a[d][g]);
            rq[d][g].push_back(x);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always begin : mon
        gexp_t e;
        rexp_t x;
        @(negedge clk or mid_ev);
        if (done) begin
            for (int d = 0; d < 2; d++) begin
                total++;
                if (gq[d].size() == 0) passed++;
                else $display("FAIL grant_drain d%0d: %0d expected grants never seen, required 0", d, gq[d].size());
                for (int i = 0; i < 2; i++) begin
                    total++;
                    if (rq[d][i].size() == 0) passed++;
                    else $display("FAIL rvalid_drain d%0d m%0d: %0d expected reads never returned, required 0", d, i, rq[d][i].size());
                end
            end
            $display("%0d/%0d checks passed", passed, total);
            $finish;
        end else if (clk) begin
            total++;
            if (rv[0][0] === mid_rv) passed++;
            else $display("FAIL mid_rvalid m0: got %b, required %b", rv[0][0], mid_rv);
            if (mid_zero) begin
                total++;
                if (!gv[0][0] && !gv[0][1] && maddr[0] == 0 && mwm[0] == 0 && mwd[0] == 0 && !mrs[0]) passed++;
                else $display("FAIL reset_bus: gnt=%b%b addr=%h wmask=%h wdata=%h rstrb=%b, required all 0",
                              gv[0][1], gv[0][0], maddr[0], mwm[0], mwd[0], mrs[0]);
                rq[0][0].delete();
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!gv[d][0] && !gv[d][1]) begin
                    total++;
                    if (maddr[d] == 0 && mwm[d] == 0 && mwd[d] == 0 && !mrs[d]) passed++;
                    else $display("FAIL idle_bus d%0d @%0d: addr=%h wmask=%h wdata=%h rstrb=%b, required all 0",
                                  d, cyc, maddr[d], mwm[d], mwd[d], mrs[d]);
                end
                for (int i = 0; i < 2; i++) begin
                    if (gv[d][i]) begin
                        total++;
                        if (gq[d].size() == 0) begin
                            $display("FAIL grant d%0d m%0d @%0d: unexpected grant, required none", d, i, cyc);
                        end else begin
                            e = gq[d].pop_front();
                            if (e.cyc == cyc && e.who == i && maddr[d] == e.addr && mwm[d] == e.wmask &&
                                mwd[d] == e.wdata && mrs[d] == e.rstrb) passed++;
                            else $display("FAIL grant d%0d @%0d: got m%0d addr=%h wmask=%h wdata=%h rstrb=%b, required @%0d m%0d addr=%h wmask=%h wdata=%h rstrb=%b",
                                          d, cyc, i, maddr[d], mwm[d], mwd[d], mrs[d],
                                          e.cyc, e.who, e.addr, e.wmask, e.wdata, e.rstrb);
                        end
                    end
                    if (rv[d][i]) begin
                        total++;
                        if (rq[d][i].size() == 0) begin
                            $display("FAIL rvalid d%0d m%0d @%0d: unexpected rvalid, required none", d, i, cyc);
                        end else begin
                            x = rq[d][i].pop_front();
                            if (x.cyc == cyc && rd[d][i] == x.data) passed++;
                            else $display("FAIL rvalid d%0d m%0d: got @%0d data=%h, required @%0d data=%h",
                                          d, i, cyc, rd[d][i], x.cyc, x.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int g, n0, n1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) drv(d, p, 1'b0, 32'h0, 4'h0, 32'h0);
        // a request held during reset must not be granted
        drv(0, 0, 1'b1, 32'h44, 4'h0, 32'h0);
        repeat (3) tick();
        drv(0, 0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst_n = 1'b1;

        // m0 read of 0x10 returns 0xDEADBEEF one cycle later
        drv(0, 0, 1'b1, 32'h10, 4'h0, 32'h0); exp(0, 0); tick();
        drv(0, 0, 1'b0, 32'h0, 4'h0, 32'h0); tick();

        // m1 partial write, no read strobe and no rvalid
        drv(0, 1, 1'b1, 32'h20, 4'b0011, 32'hA5A5A5A5); exp(0, 1); tick();
        drv(0, 1, 1'b0, 32'h0, 4'h0, 32'h0); tick();

        // reset with owner at m1 so contention must restart at m0
        rst_n = 1'b0; tick(); rst_n = 1'b1;

        // continuous contention: m0 x4, m1 x4, m0 x4
        n0 = 0; n1 = 0;
        for (int i = 0; i < 12; i++) begin
            g = (i >= 4 && i < 8) ? 1 : 0;
            drv(0, 0, 1'b1, 32'h100 + 32'(n0) * 4, 4'h0, 32'h0);
            drv(0, 1, 1'b1, 32'h180 + 32'(n1) * 4, 4'hF, 32'h1000 + 32'(n1));
            exp(0, g); tick();
            if (g == 0) n0++; else n1++;
        end
        drv(0, 0, 1'b0, 32'h0, 4'h0, 32'h0); drv(0, 1, 1'b0, 32'h0, 4'h0, 32'h0); tick();

        // m0 alone 10 cycles (counter saturates), then m1 wins immediately
        for (int i = 0; i < 10; i++) begin
            drv(0, 0, 1'b1, 32'h200 + 32'(i) * 4, 4'h0, 32'h0); exp(0, 0); tick();
        end
        drv(0, 0, 1'b1, 32'h228, 4'h0, 32'h0);
        drv(0, 1, 1'b1, 32'h240, 4'b1000, 32'h77000000); exp(0, 1); tick();
        drv(0, 1, 1'b0, 32'h0, 4'h0, 32'h0); exp(0, 0); tick();
        drv(0, 0, 1'b0, 32'h0, 4'h0, 32'h0); tick();

        // reset one cycle after an m0 read grant: in-flight read is dropped
        drv(0, 1, 1'b1, 32'h300, 4'hF, 32'hCAFEF00D); exp(0, 1); tick();
        drv(0, 1, 1'b0, 32'h0, 4'h0, 32'h0);
        drv(0, 0, 1'b1, 32'h30C, 4'h0, 32'h0); exp(0, 0); tick();
        drv(0, 0, 1'b1, 32'h310, 4'h0, 32'h0);
        mid_rv = 1'b1; mid_zero = 1'b0; -> mid_ev;
        #2 rst_n = 1'b0;
        #1 mid_rv = 1'b0; mid_zero = 1'b1; -> mid_ev;
        tick();
        rst_n = 1'b1;
        exp(0, 0); tick();
        // counter restarted at 0: three more m0, then m1 twice
        for (int i = 0; i < 5; i++) begin
            g = (i < 3) ? 0 : 1;
            drv(0, 0, 1'b1, 32'h314 + 32'(i) * 4, 4'h0, 32'h0);
            drv(0, 1, 1'b1, 32'h400 + 32'(i - 3) * 4, 4'h0, 32'h0);
            exp(0, g); tick();
        end
        drv(0, 0, 1'b0, 32'h0, 4'h0, 32'h0); drv(0, 1, 1'b0, 32'h0, 4'h0, 32'h0); tick();

        // BURST_LEN=1: strict alternation, rvalid only on the issuer
        n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            g = i % 2;
            drv(1, 0, 1'b1, 32'h500 + 32'(n0) * 4, 4'h0, 32'h0);
            drv(1, 1, 1'b1, 32'h600 + 32'(n1) * 4, 4'h0, 32'h0);
            exp(1, g); tick();
            if (g == 0) n0++; else n1++;
        end
        drv(1, 0, 1'b0, 32'h0, 4'h0, 32'h0); drv(1, 1, 1'b0, 32'h0, 4'h0, 32'h0);
        tick(); tick();
        done = 1'b1;
        #1000;
        $display("FAIL timeout: monitor did not reach summary, required finish");
        $fatal(1);
    end
endmodule
